// File: rtl/top_v_pkg.sv
// Shared constants and types for the registered population counter.
package top_v_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 4;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [CNT_W_DEF-1:0]  cnt_t;

endpackage

// File: rtl/top_v_popcount.sv
// Combinational population count of a DATA_W-bit word into a CNT_W-bit result.
module popcount
  import top_v_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  output logic [CNT_W-1:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      cnt = cnt + CNT_W'(a[i]);
    end
  end

endmodule

// File: rtl/top_v.sv
// Registered population counter; define TOP_V_PARITY_EN to add the
// registered parity output that captures alongside q.
module top_v
  import top_v_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] a,
`ifdef TOP_V_PARITY_EN
  output logic              parity,
`endif
  output logic [CNT_W-1:0]  q
);

  logic [CNT_W-1:0] cnt;

  popcount #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_popcount (
    .a   (a),
    .cnt (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= cnt;
    end
  end

`ifdef TOP_V_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^a;
    end
  end
`endif

endmodule

// File: tb/tb_top_v.sv
// Directed self-checking bench for top_v (q, plus parity when TOP_V_PARITY_EN is defined).
module tb_top_v;
  import top_v_pkg::*;

  logic  clk;
  logic  rst;
  logic  load;
  data_t a;
  cnt_t  q;
`ifdef TOP_V_PARITY_EN
  logic  parity;
`endif

  int unsigned total;
  int unsigned bad;

  top_v #(
    .DATA_W (DATA_W_DEF),
    .CNT_W  (CNT_W_DEF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .a      (a),
`ifdef TOP_V_PARITY_EN
    .parity (parity),
`endif
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference count by repeatedly clearing the lowest set bit.
  function automatic int unsigned ref_pop(input data_t v);
    data_t w;
    int unsigned n;
    w = v;
    n = 0;
    while (w != '0) begin
      w = w & (w - 1'b1);
      n++;
    end
    return n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input data_t src);
    check(tag, 32'(q), ref_pop(src));
`ifdef TOP_V_PARITY_EN
    check({tag, "_par"}, 32'(parity), 32'(^src));
    check({tag, "_par_q0"}, 32'(parity), 32'(ref_pop(src) & 1));
`endif
  endtask

  data_t seq_a [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
  int unsigned seq_q [4] = '{1, 2, 3, 4};

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    load  = 1'b1;
    a     = 8'hFF;

    // Reset asserted between edges clears q immediately and holds it.
    #2 rst = 1'b1;
    #1 check("rst_immediate", 32'(q), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold", 32'(q), 32'd0);
`ifdef TOP_V_PARITY_EN
      check("rst_hold_par", 32'(parity), 32'd0);
`endif
    end
    rst = 1'b0;

    // Extremes.
    a = 8'h00; tick(); check("ext_00", 32'(q), 32'd0);
    a = 8'hFF; tick(); check("ext_ff", 32'(q), 32'd8);
    a = 8'h80; tick(); check("ext_80", 32'(q), 32'd1);
    check_out("ext_80_full", 8'h80);

    // Hold with load low.
    a = 8'hA5; tick(); check("hold_load", 32'(q), 32'd4);
    load = 1'b0;
    a = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold", 32'(q), 32'd4);
`ifdef TOP_V_PARITY_EN
      check("hold_par", 32'(parity), 32'd0);
`endif
    end
    load = 1'b1;

    // One-cycle latency: q only follows a after the edge.
    for (int i = 0; i < 4; i++) begin
      a = seq_a[i];
      if (i > 0) check("lat_pre", 32'(q), seq_q[i-1]);
      tick();
      check("lat", 32'(q), seq_q[i]);
    end

    // Random words against the reference count.
    for (int i = 0; i < 10; i++) begin
      a = data_t'($urandom);
      tick();
      check_out("rand", a);
    end

    // Mid-stream async reset; the capture on the reset edge is discarded.
    a = 8'h7F; tick(); check("mid_load", 32'(q), 32'd7);
    #2 rst = 1'b1;
    #1 check("mid_rst", 32'(q), 32'd0);
`ifdef TOP_V_PARITY_EN
    check("mid_rst_par", 32'(parity), 32'd0);
`endif
    tick();
    check("mid_rst_edge", 32'(q), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_recover", 32'(q), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
